// File: rtl/shreg_pkg.sv
// Shared definitions for the shift-register serializer.
//   state_t        : serializer FSM state encoding (IDLE, SHIFT)
//   DEFAULT_WIDTH  : default parallel word width in bits
package shreg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 16;

endpackage : shreg_pkg

// File: rtl/shreg_serializer.sv
// Parallel-to-serial shift register with valid/ready handshakes on both sides.
// A word offered on load_* while idle is captured and emitted one bit per
// accepted beat on sout*, MSB or LSB first. One bubble cycle separates words.
//
// Parameters
//   WIDTH      : word width in bits (2..32)
//   MSB_FIRST  : 1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   clr        : synchronous abort/clear, highest priority
//   load_valid : parallel word offered
//   load_ready : block can accept a word (idle)
//   load_data  : parallel word
//   sout       : serial data bit
//   sout_valid : sout holds a valid bit
//   sout_ready : consumer accepts the current bit
//   sout_last  : current bit is the final bit of the word
//   busy       : a word is being serialized
module shreg_serializer
  import shreg_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CW-1:0]    cnt_q,   cnt_d;

  logic             beat;

  // Outputs depend only on registered state, never on inputs.
  assign beat = (state_q == SHIFT) && sout_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    if (clr) begin
      state_d = IDLE;
      data_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            state_d = SHIFT;
            data_d  = load_data;
            cnt_d   = CW'(WIDTH - 1);
          end
        end
        SHIFT: begin
          // load_valid is deliberately ignored here.
          if (beat) begin
            if (MSB_FIRST) begin
              data_d = {data_q[WIDTH-2:0], 1'b0};
            end else begin
              data_d = {1'b0, data_q[WIDTH-1:1]};
            end
            if (cnt_q == '0) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          data_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == SHIFT);
  assign sout_valid = (state_q == SHIFT);
  assign sout_last  = (state_q == SHIFT) && (cnt_q == '0);
  // In IDLE the register is zero after reset, clear or a completed word,
  // so sout reads 0 there as well.
  assign sout       = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];

endmodule : shreg_serializer

// File: tb/tb_shreg_serializer.sv
// Directed bench for shreg_serializer: a 16-bit MSB-first instance and an
// 8-bit LSB-first instance sharing one clock.
module tb_shreg_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        sout;
  logic        sout_valid;
  logic        sout_ready;
  logic        sout_last;
  logic        busy;

  logic        b_clr;
  logic        b_load_valid;
  logic        b_load_ready;
  logic [7:0]  b_load_data;
  logic        b_sout;
  logic        b_sout_valid;
  logic        b_sout_ready;
  logic        b_sout_last;
  logic        b_busy;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  shreg_serializer #(.WIDTH(16), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  shreg_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .clr        (b_clr),
    .load_valid (b_load_valid),
    .load_ready (b_load_ready),
    .load_data  (b_load_data),
    .sout       (b_sout),
    .sout_valid (b_sout_valid),
    .sout_ready (b_sout_ready),
    .sout_last  (b_sout_last),
    .busy       (b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Idle/reset output pattern of the 16-bit instance: {ready,valid,last,busy,sout}
  task automatic chk_idle(input string tag);
    chk(tag, {27'd0, load_ready, sout_valid, sout_last, busy, sout}, 32'b10000);
  endtask

  task automatic load16(input logic [15:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
  endtask

  logic [15:0] w_a5c3 = 16'b1010_0101_1100_0011;
  logic [7:0]  w_96_lsb_stream = 8'b0110_1001; // stream order, index 0 first
  int unsigned cycles;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; load_valid = 1'b0; load_data = '0; sout_ready = 1'b1;
    b_clr = 1'b0; b_load_valid = 1'b0; b_load_data = '0; b_sout_ready = 1'b1;
    #3;
    chk_idle("reset_outputs");
    chk("reset_data", {16'd0, dut.data_q}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk_idle("post_reset_idle");

    // 1) 0xA5C3, MSB first, consumer always ready.
    load16(16'hA5C3);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("s1_sout_%0d", i), {31'd0, sout}, {31'd0, w_a5c3[15-i]});
      chk($sformatf("s1_vlb_%0d", i), {29'd0, sout_valid, sout_last, busy},
          {29'd0, 1'b1, (i == 15), 1'b1});
      tick();
    end
    chk_idle("s1_bubble_ready");

    // 2) Same word, 3-cycle stall while stream index 5 (value 1) is presented.
    load16(16'hA5C3);
    cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        sout_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          chk($sformatf("s2_hold_%0d", s), {30'd0, sout, sout_last}, 32'b10);
          tick();
          cycles++;
        end
        sout_ready = 1'b1;
      end
      chk($sformatf("s2_sout_%0d", i), {31'd0, sout}, {31'd0, w_a5c3[15-i]});
      if (i == 15) chk("s2_last", {31'd0, sout_last}, 32'd1);
      tick();
      cycles++;
    end
    chk("s2_cycles", cycles, 32'd19);
    chk_idle("s2_bubble_ready");

    // 3) clr while stream index 7 is presented.
    load16(16'hA5C3);
    repeat (7) tick();
    chk("s3_bit7", {31'd0, sout}, {31'd0, w_a5c3[8]});
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_idle("s3_after_clr");
    chk("s3_data_zero", {16'd0, dut.data_q}, 32'd0);
    // clr with load_valid in the same cycle: load is discarded.
    clr = 1'b1; load_valid = 1'b1; load_data = 16'hFFFF;
    tick();
    clr = 1'b0; load_valid = 1'b0;
    chk_idle("s3_clr_beats_load");

    // 4) Asynchronous reset mid-word, then 0x0001.
    load16(16'hA5C3);
    repeat (4) tick();
    chk("s4_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_idle("s4_async_reset");
    tick();
    rst = 1'b0;
    tick();
    chk_idle("s4_resume_idle");
    load16(16'h0001);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("s4_sout_last_%0d", i), {30'd0, sout, sout_last},
          {30'd0, (i == 15), (i == 15)});
      tick();
    end
    chk_idle("s4_done");

    // 5) load_valid with 0xFFFF during SHIFT of 0x0000 is ignored.
    load16(16'h0000);
    load_valid = 1'b1; load_data = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("s5_sout_%0d", i), {30'd0, sout, sout_valid}, 32'b01);
      if (i == 15) load_valid = 1'b0;
      tick();
    end
    chk_idle("s5_no_capture");
    chk("s5_data_zero", {16'd0, dut.data_q}, 32'd0);

    // 6) 8-bit LSB-first, 0x96.
    b_load_valid = 1'b1; b_load_data = 8'h96;
    tick();
    b_load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("s6_sout_%0d", i), {30'd0, b_sout, b_sout_last},
          {30'd0, w_96_lsb_stream[7-i], (i == 7)});
      chk($sformatf("s6_valid_%0d", i), {30'd0, b_sout_valid, b_load_ready}, 32'b10);
      tick();
    end
    chk("s6_bubble", {30'd0, b_load_ready, b_busy}, 32'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_shreg_serializer
